// File: rtl/rv_wb_pkg.sv
// Shared types and constants for the register write-back buffer.
package rv_wb_pkg;

    localparam int unsigned XLEN      = 64;
    localparam int unsigned REG_IDX_W = 5;

    // One pending register-file write.
    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    // Buffer occupancy states.
    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

endpackage : rv_wb_pkg

// File: rtl/wb_fifo.sv
// Pending-write storage: circular buffer of {rd, data} with occupancy tracking.
// All entries are exposed so the parent can search them for forwarding.
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              push,
    input  logic [REG_IDX_W-1:0]              push_rd,
    input  logic [WIDTH-1:0]                  push_data,
    input  logic                              pop,
    output logic                              empty_c,
    output logic                              full_c,
    output logic [REG_IDX_W-1:0]              head_rd_c,
    output logic [WIDTH-1:0]                  head_data_c,
    output logic [PTR_W-1:0]                  rd_ptr,
    output logic [CNT_W-1:0]                  count,
    output logic [DEPTH-1:0][REG_IDX_W-1:0]   ent_rd,
    output logic [DEPTH-1:0][WIDTH-1:0]       ent_data
);

    logic [PTR_W-1:0]                rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]                wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]                count_q, count_d;
    logic [1:0]                      occ_q, occ_d;
    logic [DEPTH-1:0][REG_IDX_W-1:0] rd_mem_q, rd_mem_d;
    logic [DEPTH-1:0][WIDTH-1:0]     data_mem_q, data_mem_d;

    // Next-state: storage writes, pointer advance (natural modulo-DEPTH wrap), count and occupancy.
    always_comb begin
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        occ_d      = occ_q;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;

        if (push) begin
            rd_mem_d[wr_ptr_q]   = push_rd;
            data_mem_d[wr_ptr_q] = push_data;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (count_d == CNT_W'(0)) begin
            occ_d = OCC_EMPTY;
        end else if (count_d == CNT_W'(DEPTH)) begin
            occ_d = OCC_FULL;
        end else begin
            occ_d = OCC_PARTIAL;
        end
    end

    // State register; reset drops every pending entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            occ_q      <= OCC_EMPTY;
            rd_mem_q   <= '0;
            data_mem_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            occ_q      <= occ_d;
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
        end
    end

    // Head view reads as zero when nothing is pending.
    always_comb begin
        empty_c     = (occ_q == OCC_EMPTY);
        full_c      = (occ_q == OCC_FULL);
        head_rd_c   = empty_c ? REG_IDX_W'(0) : rd_mem_q[rd_ptr_q];
        head_data_c = empty_c ? WIDTH'(0)     : data_mem_q[rd_ptr_q];
    end

    assign rd_ptr   = rd_ptr_q;
    assign count    = count_q;
    assign ent_rd   = rd_mem_q;
    assign ent_data = data_mem_q;

endmodule : wb_fifo

// File: rtl/reg_writeback.sv
// Register write-back stage: buffers memory-stage results and drains them to
// the register file in order, stalling while the write port is held.
// Define REG_WB_FWD_EN to compile in forwarding from the pending buffer;
// otherwise the fwd_* outputs are tied to zero.
module reg_writeback
    import rv_wb_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [REG_IDX_W-1:0] in_rd,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 wb_hold,
    output logic                 regWrite,
    output logic [REG_IDX_W-1:0] writeReg,
    output logic [WIDTH-1:0]     dataWrite,
    input  logic [REG_IDX_W-1:0] fwd_rs1,
    input  logic [REG_IDX_W-1:0] fwd_rs2,
    output logic                 fwd_hit1,
    output logic                 fwd_hit2,
    output logic [WIDTH-1:0]     fwd_data1,
    output logic [WIDTH-1:0]     fwd_data2
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                            push_c;
    logic                            pop_c;
    logic                            empty_c;
    logic                            full_c;
    logic [REG_IDX_W-1:0]            head_rd_c;
    logic [WIDTH-1:0]                head_data_c;
    logic [PTR_W-1:0]                rd_ptr;
    logic [CNT_W-1:0]                count;
    logic [DEPTH-1:0][REG_IDX_W-1:0] ent_rd;
    logic [DEPTH-1:0][WIDTH-1:0]     ent_data;

    // Handshake: ready depends only on occupancy; x0 writes are accepted but dropped.
    always_comb begin
        in_ready  = !full_c;
        push_c    = in_valid && in_ready && (in_rd != REG_IDX_W'(0));
        regWrite  = !empty_c && !wb_hold;
        pop_c     = regWrite;
        writeReg  = head_rd_c;
        dataWrite = head_data_c;
    end

    wb_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (push_c),
        .push_rd     (in_rd),
        .push_data   (in_data),
        .pop         (pop_c),
        .empty_c     (empty_c),
        .full_c      (full_c),
        .head_rd_c   (head_rd_c),
        .head_data_c (head_data_c),
        .rd_ptr      (rd_ptr),
        .count       (count),
        .ent_rd      (ent_rd),
        .ent_data    (ent_data)
    );

`ifdef REG_WB_FWD_EN
    // Forwarding: walk entries oldest to youngest so the youngest match wins.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (CNT_W'(k) < count) begin
                if ((fwd_rs1 != REG_IDX_W'(0)) && (ent_rd[idx] == fwd_rs1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = ent_data[idx];
                end
                if ((fwd_rs2 != REG_IDX_W'(0)) && (ent_rd[idx] == fwd_rs2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = ent_data[idx];
                end
            end
        end
    end
`else
    // Forwarding compiled out; ports stay for a uniform interface.
    logic unused_fwd;
    assign unused_fwd = ^{fwd_rs1, fwd_rs2, rd_ptr, count, ent_rd, ent_data};
    assign fwd_hit1   = 1'b0;
    assign fwd_hit2   = 1'b0;
    assign fwd_data1  = '0;
    assign fwd_data2  = '0;
`endif

endmodule : reg_writeback

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter WIDTH, default 64, data width of a register write.
REQ-002 Parameter DEPTH, default 4, pending-write buffer entries, power of two, >= 2.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state.
REQ-005 in_valid  input  1  a result from the memory stage is presented.
REQ-006 in_ready  output  1  block accepts a result this cycle.
REQ-007 in_rd  input  5  destination register index.
REQ-008 in_data  input  WIDTH  result value.
REQ-009 wb_hold  input  1  register-file write port unavailable this cycle.
REQ-010 regWrite  output  1  write strobe to the register file.
REQ-011 writeReg  output  5  register-file write index.
REQ-012 dataWrite  output  WIDTH  register-file write data.
REQ-013 fwd_rs1, fwd_rs2  input  5 each  source indices from decode.
REQ-014 fwd_hit1, fwd_hit2  output  1 each  source has a pending buffered write.
REQ-015 fwd_data1, fwd_data2  output  WIDTH each  newest pending value for that source.

Function
REQ-016 Transfer on rising edge when in_valid && in_ready; in_ready = (count < DEPTH), with no dependence on the same-cycle pop.
REQ-017 Transfer with in_rd == 0 is accepted and discarded: no enqueue, no count change.
REQ-018 Entries are held in FIFO order as {rd, data}; writes leave in arrival order.
REQ-019 regWrite = !empty && !wb_hold, combinational; writeReg/dataWrite = head entry, zero when empty.
REQ-020 Head pops on the edge where regWrite is 1; minimum latency from accepted transfer to regWrite is 1 cycle.
REQ-021 Occupancy states EMPTY (count 0), PARTIAL (0<count<DEPTH), FULL (count DEPTH); push only -> count+1, pop only -> count-1, push and pop together -> count unchanged.
REQ-022 In FULL with a pop, in_ready remains 0 that cycle; it rises the following cycle.
REQ-023 Read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
REQ-024 wb_hold freezes the buffer head; accepted pushes continue until FULL.
REQ-025 fwd_hitN = 1 when any valid entry has rd == fwd_rsN and fwd_rsN != 0; fwd_dataN = data of the youngest matching entry, else 0.
REQ-026 Forwarding covers buffered entries only, including the head being written this cycle; no same-cycle in_data bypass.

Reset
REQ-027 On reset assertion, asynchronously: count 0, pointers 0, regWrite 0, writeReg 0, dataWrite 0, fwd_hit* 0, fwd_data* 0, in_ready 1 after release.
REQ-028 Reset mid-operation discards all pending writes; none reach the register file.

Configuration
REQ-029 Macro REG_WB_FWD_EN defined: forwarding logic per REQ-025/026 is compiled in.
REQ-030 Macro REG_WB_FWD_EN undefined: fwd_hit* and fwd_data* are tied to 0, ports remain present.

Structure
REQ-031 Package rv_wb_pkg holds XLEN = 64, REG_IDX_W = 5, and typedef wb_entry_t {rd, data}.
REQ-032 Storage and pointers live in sub-module wb_fifo; reg_writeback holds x0 filtering, handshake, and forwarding.

Verification
REQ-033 Push rd=5 data=0xAA after reset -> next cycle regWrite=1, writeReg=5, dataWrite=0xAA; count back to 0 after that edge.
REQ-034 wb_hold=1, push rd=1..4 -> in_ready=0 after 4th; 5th in_valid held off; release hold -> writes 1,2,3,4 on four consecutive cycles.
REQ-035 Push rd=0 data=0xFF -> accepted, regWrite never asserts, count stays 0.
REQ-036 Hold, push rd=7/0x11 then rd=7/0x22, fwd_rs1=7, fwd_rs2=0 -> fwd_hit1=1, fwd_data1=0x22, fwd_hit2=0 (macro defined); all zero when undefined.
REQ-037 FULL with hold released, in_valid=1 -> pop that cycle with in_ready=0, push accepted next cycle; order preserved across pointer wrap.
REQ-038 Assert reset with 3 pending entries -> regWrite=0 immediately, no further writes after release.
